// File: rtl/parity_arb_pkg.sv
// Shared types and constants for the parity check arbiter.
package parity_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned DW_DEF   = 4;

  // Width of a requester index; never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IDW_DEF = id_width(NREQ_DEF);

endpackage

// File: rtl/rr_grant_select.sv
// Combinational round-robin grant: first valid requester at or after ptr, wrapping modulo N.
module rr_grant_select
  import parity_arb_pkg::*;
#(
  parameter  int unsigned N  = NREQ_DEF,
  localparam int unsigned IW = id_width(N)
) (
  input  logic [N-1:0]  req_valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [IW-1:0] pos;

  // Walk the requesters starting at ptr and keep the first valid one.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    pos     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = IW'((32'(ptr) + k) % N);
      if (!gnt_any && req_valid[pos]) begin
        gnt[pos] = 1'b1;
        gnt_idx  = pos;
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parity_check_arbiter.sv
// Round-robin sharing of one parity checker between NREQ requesters.
// Optional saturating error counter enabled by PARITY_ARB_ERR_COUNT_EN.
module parity_check_arbiter
  import parity_arb_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  parameter  int unsigned DW   = DW_DEF,
  parameter  int unsigned ECW  = 8,
  localparam int unsigned IDW  = id_width(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_check,
  output logic               busy,
  output logic [ECW-1:0]     err_count
);

  state_t          state_q, state_d;
  logic            accept_c, rsp_hs_c;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx, ptr_q;
  logic            gnt_any;
  logic [DW-1:0]   sel_data;

  rr_grant_select #(.N(NREQ)) u_sel (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_any   (gnt_any)
  );

  // Ready goes only to the winner while idle, and never during reset.
  assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;

  // Pick the granted requester's word.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel_data = req_data[i*DW +: DW];
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    rsp_hs_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          accept_c = 1'b1;
          state_d  = CHECK;
        end
      end
      CHECK: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          rsp_hs_c = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Capture the accepted word, advance the pointer and register response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_check <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= (state_d == RESP);
      busy      <= (state_d != IDLE);
      if (accept_c) begin
        rsp_id   <= gnt_idx;
        rsp_data <= sel_data;
        ptr_q    <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      end
      if (state_q == CHECK) rsp_check <= ^rsp_data;
    end
  end

`ifdef PARITY_ARB_ERR_COUNT_EN
  logic [ECW-1:0] err_q;

  // Count odd-parity responses at handshake, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                    err_q <= '0;
    else if (rsp_hs_c && rsp_check && err_q != {ECW{1'b1}})     err_q <= err_q + ECW'(1);
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Randomized self-checking bench for parity_check_arbiter with a transaction-level model.
module tb_parity_check_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 4;
  localparam int unsigned ECW  = 8;
  localparam int unsigned IDW  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_data;
  logic               rsp_check;
  logic               busy;
  logic [ECW-1:0]     err_count;

  parity_check_arbiter #(.NREQ(NREQ), .DW(DW), .ECW(ECW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_check (rsp_check),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: one word in flight, age 0 = being checked, age 1 = response offered.
  bit          in_flight;
  int          age;
  int          ptr_m;
  int          errs_m;
  int          e_id;
  logic [DW-1:0] e_data;
  int          q_id[$];
  int          q_chk[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < int'(NREQ); k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int odd_ones(input logic [DW-1:0] w);
    return $countones(w) % 2;
  endfunction

  // One clock cycle: drive, check against model, advance model, wait to next negedge.
  task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] d,
                       input logic rr, output bit acc);
    int g;
    logic [NREQ-1:0] er;
    req_valid = v;
    req_data  = d;
    rsp_ready = rr;
    #1;
    g  = pick(v, ptr_m);
    er = (!in_flight && g >= 0) ? (NREQ'(1) << g) : '0;
    check("req_ready", 32'(req_ready), 32'(er));
    check("busy", 32'(busy), 32'(in_flight));
    check("rsp_valid", 32'(rsp_valid), 32'(in_flight && age == 1));
    check("err_count", 32'(err_count), 32'(errs_m));
    if (in_flight && age == 1) begin
      check("rsp_id", 32'(rsp_id), 32'(e_id));
      check("rsp_data", 32'(rsp_data), 32'(e_data));
      check("rsp_check", 32'(rsp_check), 32'(odd_ones(e_data)));
    end
    if (rsp_valid && rr) begin
      q_id.push_back(int'(rsp_id));
      q_chk.push_back(int'(rsp_check));
    end
    acc = 1'b0;
    if (!in_flight) begin
      if (g >= 0) begin
        in_flight = 1'b1;
        age       = 0;
        e_id      = g;
        e_data    = d[g*DW +: DW];
        ptr_m     = (g + 1) % NREQ;
        acc       = 1'b1;
      end
    end else if (age == 0) begin
      age = 1;
    end else if (rr) begin
`ifdef PARITY_ARB_ERR_COUNT_EN
      if (odd_ones(e_data) == 1 && errs_m < (1 << ECW) - 1) errs_m++;
`endif
      in_flight = 1'b0;
    end
    @(negedge clk);
  endtask

  // Hold reset for n cycles with random traffic; outputs must sit at reset values.
  task automatic reset_dut(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      req_valid = NREQ'($urandom);
      req_data  = (NREQ*DW)'($urandom);
      rsp_ready = 1'($urandom);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_err_count", 32'(err_count), 32'h0);
      check("rst_rsp_id", 32'(rsp_id), 32'h0);
      check("rst_rsp_data", 32'(rsp_data), 32'h0);
      check("rst_rsp_check", 32'(rsp_check), 32'h0);
      @(negedge clk);
    end
    rst       = 1'b0;
    in_flight = 1'b0;
    age       = 0;
    ptr_m     = 0;
    errs_m    = 0;
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 4; i++) cycle('0, '0, 1'b1, acc);
  endtask

  task automatic random_cycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++)
      cycle(NREQ'($urandom), (NREQ*DW)'($urandom), ($urandom_range(9, 0) < 7), acc);
  endtask

  initial begin
    bit acc;
    bit got;
    int exp_id[5]  = '{0, 1, 2, 3, 0};
    int exp_chk[5] = '{0, 1, 0, 1, 0};
    int exp_errs;

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    reset_dut(3);

    // Reset in the middle of traffic, then first grant must be requester 0.
    random_cycles(7);
    reset_dut(3);
    req_valid = '1;
    #1;
    check("grant_after_reset", 32'(req_ready), 32'h1);
    cycle('1, (NREQ*DW)'($urandom), 1'b1, acc);
    drain();

    // Single requester 2 with word 0111.
    reset_dut(1);
    cycle(4'b0100, 16'h0700, 1'b0, acc);
    cycle('0, '0, 1'b0, acc);
    cycle('0, '0, 1'b0, acc);
    check("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check("single_rsp_id", 32'(rsp_id), 32'h2);
    check("single_rsp_data", 32'(rsp_data), 32'h7);
    check("single_rsp_check", 32'(rsp_check), 32'h1);
    cycle('0, '0, 1'b1, acc);
    drain();

    // Round-robin fairness with all requesters valid.
    reset_dut(1);
    q_id.delete();
    q_chk.delete();
    for (int i = 0; i < 16; i++) cycle('1, 16'h7310, 1'b1, acc);
    check("fair_count", 32'(q_id.size() >= 5), 32'h1);
    for (int i = 0; i < 5; i++) begin
      check("fair_id", (i < q_id.size()) ? 32'(q_id[i]) : 32'hFFFF, 32'(exp_id[i]));
      check("fair_chk", (i < q_chk.size()) ? 32'(q_chk[i]) : 32'hFFFF, 32'(exp_chk[i]));
    end
    drain();

    // Backpressure: hold rsp_ready low in RESP, others keep requesting.
    cycle(4'b0001, 16'h000B, 1'b0, acc);
    for (int i = 0; i < 6; i++) cycle('1, 16'hFFFF, 1'b0, acc);
    cycle('1, 16'hFFFF, 1'b1, acc);
    cycle('1, 16'hFFFF, 1'b1, acc);
    check("bp_reaccept", 32'(acc), 32'h1);
    drain();

    // Exhaustive sweep of requester 0.
    reset_dut(1);
    for (int val = 0; val < 16; val++) begin
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        cycle(4'b0001, 16'(val), 1'b1, acc);
        got = acc;
      end
      check("sweep_accept", 32'(got), 32'h1);
    end
    drain();
`ifdef PARITY_ARB_ERR_COUNT_EN
    exp_errs = 8;
`else
    exp_errs = 0;
`endif
    #1;
    check("sweep_err_count", 32'(err_count), 32'(exp_errs));

    // Reset while the word is being checked.
    cycle(4'b0010, 16'h0050, 1'b1, acc);
    #1;
    check("midcheck_busy", 32'(busy), 32'h1);
    check("midcheck_valid", 32'(rsp_valid), 32'h0);
    reset_dut(1);
    req_valid = '1;
    #1;
    check("grant_after_midcheck", 32'(req_ready), 32'h1);
    for (int i = 0; i < 4; i++) cycle('0, '0, 1'b1, acc);

    // Long randomized run.
    random_cycles(400);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
